// File: rtl/set_pkg.sv
// Shared widths, job bundle and FSM encoding for the
// circle-set job dispatcher.
package set_pkg;

  localparam int CENTRAL_W = 24;
  localparam int RADIUS_W  = 12;
  localparam int CAND_W    = 8;

  typedef enum logic [1:0] {
    MODE_A,
    MODE_UNION,
    MODE_DIFF,
    MODE_INTER
  } mode_e;

  typedef struct packed {
    logic [CENTRAL_W-1:0] central;
    logic [RADIUS_W-1:0]  radius;
    mode_e                mode;
  } job_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_HOLD
  } state_e;

endpackage

// File: rtl/set_job_fifo.sv
// Job FIFO: DEPTH entries of {job, tag}, wrap-bit pointers,
// pushes refused when full, pops refused when empty.
module set_job_fifo
  import set_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  job_t             din_job,
  input  logic [TAG_W-1:0] din_tag,
  output job_t             dout_job,
  output logic [TAG_W-1:0] dout_tag,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  job_t             mem_job [DEPTH];
  logic [TAG_W-1:0] mem_tag [DEPTH];
  logic [AW:0]      wp;
  logic [AW:0]      rp;
  logic             do_push;
  logic             do_pop;

  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) &&
                 (wp[AW-1:0] == rp[AW-1:0]);

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  assign dout_job = mem_job[rp[AW-1:0]];
  assign dout_tag = mem_tag[rp[AW-1:0]];

  // Pointer advance; reset empties the queue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
    end
  end

  // Storage write; contents are don't-care until pushed.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_job[wp[AW-1:0]] <= din_job;
      mem_tag[wp[AW-1:0]] <= din_tag;
    end
  end

endmodule

// File: rtl/set_job_dispatcher.sv
// Buffers circle-set jobs and feeds SET one at a time.
// Optional watchdog: define SET_DISP_TIMEOUT_EN.
module set_job_dispatcher
  import set_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int TAG_W       = 6,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 job_valid,
  output logic                 job_ready,
  input  logic [CENTRAL_W-1:0] job_central,
  input  logic [RADIUS_W-1:0]  job_radius,
  input  logic [1:0]           job_mode,
  output logic                 set_en,
  output logic [CENTRAL_W-1:0] set_central,
  output logic [RADIUS_W-1:0]  set_radius,
  output logic [1:0]           set_mode,
  input  logic                 set_busy,
  input  logic                 set_valid,
  input  logic [CAND_W-1:0]    set_candidate,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [CAND_W-1:0]    res_candidate,
  output logic [TAG_W-1:0]     res_tag,
  output logic                 res_err
);

  job_t             in_job;
  job_t             head_job;
  logic [TAG_W-1:0] head_tag;
  logic [TAG_W-1:0] tag_cnt;
  logic [TAG_W-1:0] op_tag;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  state_e           state;

  assign in_job    = '{central: job_central,
                       radius:  job_radius,
                       mode:    mode_e'(job_mode)};
  assign job_ready = ~full;
  assign push      = job_valid & ~full;
  assign pop       = (state == S_IDLE) & ~empty & ~set_busy;

  set_job_fifo #(
    .DEPTH (DEPTH),
    .TAG_W (TAG_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .din_job  (in_job),
    .din_tag  (tag_cnt),
    .dout_job (head_job),
    .dout_tag (head_tag),
    .full     (full),
    .empty    (empty)
  );

  // Sequence tag advances on every accepted push.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tag_cnt <= '0;
    else if (push) tag_cnt <= tag_cnt + 1'b1;
  end

`ifdef SET_DISP_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wd;
  logic            err_q;
  assign res_err = err_q;

  // Issue/wait/hold sequencer with watchdog on WAIT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      set_en        <= 1'b0;
      set_central   <= '0;
      set_radius    <= '0;
      set_mode      <= '0;
      op_tag        <= '0;
      res_valid     <= 1'b0;
      res_candidate <= '0;
      res_tag       <= '0;
      err_q         <= 1'b0;
      wd            <= '0;
    end else begin
      set_en <= 1'b0;
      case (state)
        S_IDLE: if (pop) begin
          set_central <= head_job.central;
          set_radius  <= head_job.radius;
          set_mode    <= head_job.mode;
          op_tag      <= head_tag;
          set_en      <= 1'b1;
          wd          <= '0;
          state       <= S_ISSUE;
        end
        S_ISSUE: state <= S_WAIT;
        S_WAIT: if (set_valid) begin
          res_candidate <= set_candidate;
          res_tag       <= op_tag;
          err_q         <= 1'b0;
          res_valid     <= 1'b1;
          state         <= S_HOLD;
        end else if (wd == WD_W'(TIMEOUT_CYC - 1)) begin
          res_candidate <= '1;
          res_tag       <= op_tag;
          err_q         <= 1'b1;
          res_valid     <= 1'b1;
          state         <= S_HOLD;
        end else begin
          wd <= wd + 1'b1;
        end
        S_HOLD: if (res_ready) begin
          res_valid <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
`else
  assign res_err = 1'b0;

  // Issue/wait/hold sequencer; WAIT has no time limit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      set_en        <= 1'b0;
      set_central   <= '0;
      set_radius    <= '0;
      set_mode      <= '0;
      op_tag        <= '0;
      res_valid     <= 1'b0;
      res_candidate <= '0;
      res_tag       <= '0;
    end else begin
      set_en <= 1'b0;
      case (state)
        S_IDLE: if (pop) begin
          set_central <= head_job.central;
          set_radius  <= head_job.radius;
          set_mode    <= head_job.mode;
          op_tag      <= head_tag;
          set_en      <= 1'b1;
          state       <= S_ISSUE;
        end
        S_ISSUE: state <= S_WAIT;
        S_WAIT: if (set_valid) begin
          res_candidate <= set_candidate;
          res_tag       <= op_tag;
          res_valid     <= 1'b1;
          state         <= S_HOLD;
        end
        S_HOLD: if (res_ready) begin
          res_valid <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_set_job_dispatcher.sv
// Scoreboard bench for set_job_dispatcher with a
// behavioural SET stub and a queue-based reference model.
module tb_set_job_dispatcher;

  logic        clk = 1'b0;
  logic        rst;
  logic        job_valid;
  logic        job_ready;
  logic [23:0] job_central;
  logic [11:0] job_radius;
  logic [1:0]  job_mode;
  logic        set_en;
  logic [23:0] set_central;
  logic [11:0] set_radius;
  logic [1:0]  set_mode;
  logic        set_busy;
  logic        set_valid;
  logic [7:0]  set_candidate;
  logic        res_valid;
  logic        res_ready;
  logic [7:0]  res_candidate;
  logic [5:0]  res_tag;
  logic        res_err;

  int checks = 0;
  int passed = 0;
  int en_cnt = 0;
  int tag_m  = 0;
  logic [14:0] sb [$];
  bit  hang = 0;
  bit  block = 0;
  bit  rr_rand = 0;
  bit  prev_en = 0;

  logic       stub_busy;
  logic [2:0] scnt;

  always #5 clk = ~clk;

  set_job_dispatcher dut (
    .clk           (clk),
    .rst           (rst),
    .job_valid     (job_valid),
    .job_ready     (job_ready),
    .job_central   (job_central),
    .job_radius    (job_radius),
    .job_mode      (job_mode),
    .set_en        (set_en),
    .set_central   (set_central),
    .set_radius    (set_radius),
    .set_mode      (set_mode),
    .set_busy      (set_busy),
    .set_valid     (set_valid),
    .set_candidate (set_candidate),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_candidate (res_candidate),
    .res_tag       (res_tag),
    .res_err       (res_err)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  // SET stub: busy 5 cycles after en, then valid one cycle.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      stub_busy     <= 1'b0;
      set_valid     <= 1'b0;
      scnt          <= '0;
      set_candidate <= '0;
    end else begin
      set_valid <= 1'b0;
      if (set_en) begin
        stub_busy <= 1'b1;
        scnt      <= 3'd5;
      end else if (stub_busy) begin
        if (scnt > 3'd1) scnt <= scnt - 3'd1;
        else if (!hang) begin
          stub_busy     <= 1'b0;
          set_valid     <= 1'b1;
          set_candidate <= set_central[7:0];
        end
      end
    end
  end
  assign set_busy = stub_busy | block;

  // Random consumer back-pressure when enabled.
  always @(posedge clk) begin
    #1;
    if (rr_rand) res_ready = 1'($urandom_range(0, 1));
  end

  // Monitor: model pushes, scoreboard pops, en spacing.
  always @(negedge clk) begin
    logic [14:0] exp;
    if (!rst) begin
      sb.delete();
      tag_m   = 0;
      prev_en = 0;
    end else begin
      if (set_en) begin
        en_cnt++;
        chk("en_gap", 32'(prev_en), 32'd0);
      end
      prev_en = set_en;
      if (res_valid && res_ready) begin
        if (sb.size() == 0) begin
          checks++;
          $display("FAIL unexpected_result: got %0h want none",
                   {res_err, res_tag, res_candidate});
        end else begin
          exp = sb.pop_front();
          chk("result", 32'({res_err, res_tag, res_candidate}),
              32'(exp));
        end
      end
      if (job_valid && job_ready) begin
        sb.push_back({hang, 6'(tag_m),
                      hang ? 8'hFF : job_central[7:0]});
        tag_m = (tag_m + 1) % 64;
      end
    end
  end

  // Offer one job starting now; leave valid high on exit
  // only until the acceptance edge has passed.
  task automatic push_job(input logic [23:0] c,
                          input logic [11:0] r,
                          input logic [1:0] m);
    int n = 0;
    job_valid   = 1'b1;
    job_central = c;
    job_radius  = r;
    job_mode    = m;
    while (1) begin
      @(negedge clk);
      if (job_ready) break;
      n++;
      if (n > 3000) begin
        chk("push_timeout", 32'd1, 32'd0);
        break;
      end
    end
    @(posedge clk);
    #1;
    job_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 || res_valid) begin
      @(posedge clk);
      #1;
      n++;
      if (n > 5000) begin
        chk("drain_timeout", 32'(sb.size()), 32'd0);
        break;
      end
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic chk_zero_outputs(input string nm);
    chk({nm, "_set_en"},    32'(set_en), 32'd0);
    chk({nm, "_res_valid"}, 32'(res_valid), 32'd0);
    chk({nm, "_res_cand"},  32'(res_candidate), 32'd0);
    chk({nm, "_res_tag"},   32'(res_tag), 32'd0);
    chk({nm, "_res_err"},   32'(res_err), 32'd0);
    chk({nm, "_set_cen"},   32'(set_central), 32'd0);
    chk({nm, "_job_rdy"},   32'(job_ready), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

  initial begin
    int e0;
    int n;
    logic [7:0] held;
    rst = 1'b0;
    job_valid = 1'b0;
    job_central = '0;
    job_radius = '0;
    job_mode = '0;
    res_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_zero_outputs("reset");
    rst = 1'b1;
    @(posedge clk);
    #1;

    // single job
    en_cnt = 0;
    push_job(24'h123456, 12'habc, 2'd0);
    drain();
    chk("t1_en_cnt", 32'(en_cnt), 32'd1);

    // fill FIFO while SET is held busy
    block = 1'b1;
    e0 = en_cnt;
    for (int i = 0; i < 4; i++)
      push_job(24'($urandom), 12'($urandom), 2'($urandom));
    chk("t2_full_ready", 32'(job_ready), 32'd0);
    repeat (5) @(posedge clk);
    #1;
    chk("t2_no_issue", 32'(en_cnt), 32'(e0));
    block = 1'b0;
    drain();
    chk("t2_issued", 32'(en_cnt), 32'(e0 + 4));

    // consumer stall in HOLD
    res_ready = 1'b0;
    push_job(24'h00AB77, 12'h111, 2'd1);
    push_job(24'h00CD88, 12'h222, 2'd2);
    n = 0;
    while (!res_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("t3_res_valid", 32'(res_valid), 32'd1);
    held = res_candidate;
    e0 = en_cnt;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("t3_hold_cand", 32'(res_candidate), 32'(held));
    end
    chk("t3_no_issue", 32'(en_cnt), 32'(e0));
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    drain();
    chk("t3_next_issue", 32'(en_cnt), 32'(e0 + 1));

    // random stream past tag wrap
    rr_rand = 1'b1;
    for (int i = 0; i < 65; i++) begin
      push_job(24'($urandom), 12'($urandom), 2'($urandom));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    rr_rand = 1'b0;
    res_ready = 1'b1;
    drain();

    // reset while SET is working
    e0 = en_cnt;
    push_job(24'h5A5A5A, 12'h333, 2'd3);
    n = 0;
    while (en_cnt == e0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk_zero_outputs("mid_reset");
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    push_job(24'h0000C3, 12'h444, 2'd0);
    drain();

`ifdef SET_DISP_TIMEOUT_EN
    // watchdog expiry
    hang = 1'b1;
    push_job(24'h000042, 12'h555, 2'd1);
    drain();
    chk("t6_err_seen", 32'(sb.size()), 32'd0);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
